// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: host command sequencer for the cpu memory ports and enable; `CPU_RUN_CTRL_CYCLE_COUNT_EN adds run_cycles.
module cpu_run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [63:0]      cmd_addr,
  input  logic [63:0]      cmd_wdata,
  output logic             resp_valid,
  output logic [63:0]      resp_data,
  output logic             busy,
  output logic             enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] run_cycles
`endif
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_CAP, RUN, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, n, budget;
  logic acc;
  assign acc = cmd_valid & cmd_ready;
  assign budget = cmd_wdata[CNT_W-1:0];
  assign busy = ~cmd_ready;
  assign ren_ext = 1'b0;
  // WRITE spans two cycles: the strobe cycle, then one quiet cycle so writes and reads share latency.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = cmd_op[1] ? (cmd_op[0] ? (budget == '0 ? DONE : RUN) : RD_REQ) : WRITE;
      WRITE:   nxt = (wen_ext | wen_ext_2) ? WRITE : DONE;
      RD_REQ:  nxt = RD_CAP;
      RD_CAP:  nxt = DONE;
      RUN:     nxt = cnt == CNT_W'(1) ? DONE : RUN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      enable      <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      cnt         <= '0;
      n           <= '0;
    end else begin
      state      <= nxt;
      cmd_ready  <= nxt == IDLE;
      resp_valid <= nxt == DONE;
      enable     <= nxt == RUN;
      wen_ext    <= acc && cmd_op == 2'd0;
      wen_ext_2  <= acc && cmd_op == 2'd1;
      ren_ext_2  <= acc && cmd_op == 2'd2;
      if (acc && cmd_op == 2'd0) begin
        addr_ext  <= cmd_addr;
        wdata_ext <= cmd_wdata[31:0];
      end
      if (acc && cmd_op == 2'd1) begin
        addr_ext_2  <= cmd_addr;
        wdata_ext_2 <= cmd_wdata;
      end
      if (acc && cmd_op == 2'd2) addr_ext_2 <= cmd_addr;
      if (acc && cmd_op == 2'd3) begin
        cnt <= budget;
        n   <= budget;
        if (budget == '0) resp_data <= '0;
      end
      if (state == RUN) cnt <= cnt - CNT_W'(1);
      if (state == RUN && nxt == DONE) resp_data <= 64'(n);
      if (state == RD_CAP) resp_data <= rdata_ext_2;
    end
  end
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) run_cycles <= '0;
    else if (enable) run_cycles <= run_cycles + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized host commands checked every cycle against a latency-table model of cpu_run_ctrl.
module tb_cpu_run_ctrl;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [63:0] cmd_addr = '0, cmd_wdata = '0, rdata_ext_2 = '0;
  logic cmd_ready, resp_valid, busy, enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [63:0] resp_data, addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
  logic [CW-1:0] run_cycles;
`endif
  always #5 clk = ~clk;
  cpu_run_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .enable(enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
    , .run_cycles(run_cycles)
`endif
  );
  int vectors = 0, miscompares = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // data memory attached to the DUT pins
  logic [63:0] emem [16];
  initial foreach (emem[i]) emem[i] = '0;
  always @(posedge clk) begin
    if (wen_ext_2) emem[addr_ext_2[6:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= emem[addr_ext_2[6:3]];
  end
  logic s_rst, s_valid;
  logic [1:0] s_op;
  logic [63:0] s_addr, s_wdata;
  always @(posedge clk) begin
    s_rst   <= rst;
    s_valid <= cmd_valid;
    s_op    <= cmd_op;
    s_addr  <= cmd_addr;
    s_wdata <= cmd_wdata;
  end
  bit started = 0, active = 0, was_idle = 0;
  bit e_ready, e_en, e_wi, e_w2, e_r2, e_rv;
  int k = 0, n = 0, rc = 0;
  logic [1:0] m_op = '0;
  logic [63:0] m_a = '0, m_d = '0, x_rd = '0, x_ai = '0, x_wi = '0, x_a2 = '0, x_w2 = '0;
  logic [63:0] mm [16];
  initial begin
    foreach (mm[i]) mm[i] = '0;
    forever begin
      @(negedge clk);
      if (s_rst) begin
        started = 1; active = 0;
        x_rd = '0; x_ai = '0; x_wi = '0; x_a2 = '0; x_w2 = '0; rc = 0;
      end else if (!active && was_idle && s_valid) begin
        active = 1; k = 1; m_op = s_op; m_a = s_addr; m_d = s_wdata; n = int'(s_wdata[CW-1:0]);
      end else if (active) k++;
      e_ready = !active;
      e_wi = active && m_op == 2'd0 && k == 1;
      e_w2 = active && m_op == 2'd1 && k == 1;
      e_r2 = active && m_op == 2'd2 && k == 1;
      e_en = active && m_op == 2'd3 && k >= 1 && k <= n;
      e_rv = active && (m_op == 2'd3 ? k == n + 1 : k == 3);
      if (e_wi) begin x_ai = m_a; x_wi = 64'(m_d[31:0]); end
      if (e_w2) begin x_a2 = m_a; x_w2 = m_d; mm[m_a[6:3]] = m_d; end
      if (e_r2) x_a2 = m_a;
      if (e_rv && m_op == 2'd2) x_rd = mm[m_a[6:3]];
      if (e_rv && m_op == 2'd3) x_rd = 64'(n);
      if (started) begin
        chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
        chk("busy", 64'(busy), 64'(!e_ready));
        chk("enable", 64'(enable), 64'(e_en));
        chk("resp_valid", 64'(resp_valid), 64'(e_rv));
        chk("resp_data", resp_data, x_rd);
        chk("wen_ext", 64'(wen_ext), 64'(e_wi));
        chk("ren_ext", 64'(ren_ext), 64'h0);
        chk("wen_ext_2", 64'(wen_ext_2), 64'(e_w2));
        chk("ren_ext_2", 64'(ren_ext_2), 64'(e_r2));
        chk("addr_ext", addr_ext, x_ai);
        chk("wdata_ext", 64'(wdata_ext), x_wi);
        chk("addr_ext_2", addr_ext_2, x_a2);
        chk("wdata_ext_2", wdata_ext_2, x_w2);
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
        chk("run_cycles", 64'(run_cycles), 64'(rc));
`endif
      end
      was_idle = e_ready;
      if (e_rv) active = 0;
      if (e_en) rc = (rc + 1) % (1 << CW);
    end
  end
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] d, input bit wait_resp,
                       output logic [63:0] rd, output int ens);
    bit ok;
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("handshake_timeout", 64'h0, 64'h1);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = {$urandom, $urandom}; cmd_wdata = {$urandom, $urandom};
    rd = '0; ens = 0;
    if (wait_resp) begin
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge clk);
        if (enable) ens++;
        ok = resp_valid;
      end
      if (!ok) chk("resp_timeout", 64'h0, 64'h1);
      rd = resp_data;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] rd, a, d;
    logic [1:0] op;
    int ens;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'h1);
    chk("rst_enable", 64'(enable), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    issue(2'd0, 64'h8, 64'h0050_0093, 1, rd, ens);
    chk("imem_addr_lit", addr_ext, 64'h8);
    chk("imem_data_lit", 64'(wdata_ext), 64'h0050_0093);
    issue(2'd1, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 1, rd, ens);
    issue(2'd2, 64'h40, 64'h0, 1, rd, ens);
    chk("rd_lit", rd, 64'hDEAD_BEEF_CAFE_F00D);
    issue(2'd3, 64'h0, 64'd5, 1, rd, ens);
    chk("run5_data_lit", rd, 64'd5);
    chk("run5_enable_lit", 64'(ens), 64'd5);
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
    chk("run5_cycles_lit", 64'(run_cycles), 64'd5);
`endif
    issue(2'd3, 64'h0, 64'd3, 1, rd, ens);
    chk("run3_data_lit", rd, 64'd3);
`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
    chk("run3_cycles_lit", 64'(run_cycles), 64'd8);
`endif
    issue(2'd3, 64'h0, 64'hFFFF_FF00, 1, rd, ens);
    chk("run0_data_lit", rd, 64'd0);
    chk("run0_enable_lit", 64'(ens), 64'd0);
    issue(2'd3, 64'h0, 64'h0000_00FF, 1, rd, ens);
    chk("run_max_data_lit", rd, 64'd255);
    chk("run_max_enable_lit", 64'(ens), 64'd255);
    for (int t = 0; t < 60; t++) begin
      op = 2'($urandom_range(0, 3));
      a = op == 2'd0 ? {$urandom, $urandom} : 64'(8 * $urandom_range(0, 15));
      d = {$urandom, $urandom};
      if (op == 2'd3) d[7:0] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      issue(op, a, d, 1'($urandom_range(0, 1)), rd, ens);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    issue(2'd2, 64'h40, 64'h0, 1, rd, ens);
    issue(2'd3, 64'h0, 64'd100, 0, rd, ens);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd3; cmd_wdata = 64'd7;
    @(posedge clk);
    #1 rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_enable_lit", 64'(enable), 64'h0);
    chk("midrst_ready_lit", 64'(cmd_ready), 64'h1);
    chk("midrst_resp_lit", 64'(resp_valid), 64'h0);
    repeat (120) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Host-side sequencer for the pipelined RISC-V `cpu`. It accepts simple host commands to load instruction memory, load or read back data memory, and run the core for a bounded number of cycles. It drives the `cpu` external memory ports and its `enable` input. It is the only driver of those pins, so external memory access and pipeline execution never overlap.

## Interface

Parameters:
- `CNT_W`, default 32: width of the run-cycle budget and the cycle counter.

Ports:
- `clk`: in, 1. Clock.
- `rst`: in, 1. Reset, synchronous, active-high. All state clears on the `clk` edge where it is sampled high.
- `cmd_valid`: in, 1. Host command present.
- `cmd_ready`: out, 1. Controller can accept a command. High only in IDLE.
- `cmd_op`: in, 2. Command: 00 WR_IMEM, 01 WR_DMEM, 10 RD_DMEM, 11 RUN.
- `cmd_addr`: in, 64. Byte address for memory commands.
- `cmd_wdata`: in, 64. Write data. For WR_IMEM only [31:0] is used. For RUN, [CNT_W-1:0] is the cycle budget.
- `resp_valid`: out, 1. One-cycle pulse when a command completes. There is no backpressure.
- `resp_data`: out, 64. RD_DMEM read data, or the RUN cycle count. Held until the next response.
- `busy`: out, 1. Equals `~cmd_ready`.
- `enable`: out, 1. Drives `cpu.enable`.
- `addr_ext`: out, 64. Instruction-memory external port.
- `wen_ext`: out, 1. Instruction-memory external port.
- `ren_ext`: out, 1. Instruction-memory external port.
- `wdata_ext`: out, 32. Instruction-memory external port.
- `addr_ext_2`: out, 64. Data-memory external port.
- `wen_ext_2`: out, 1. Data-memory external port.
- `ren_ext_2`: out, 1. Data-memory external port.
- `wdata_ext_2`: out, 64. Data-memory external port.
- `rdata_ext_2`: in, 64. Data-memory read data, valid the cycle after `ren_ext_2`.
- `run_cycles`: out, CNT_W. Cumulative enabled cycles. Present only with the macro described under Configuration.

## Operation

- The FSM has six states: IDLE, WRITE, RD_REQ, RD_CAP, RUN, DONE. All outputs are registered.
- **IDLE:** `cmd_ready`=1. A command is accepted when `cmd_valid & cmd_ready`.
  - The op, address, data and budget are latched.
  - WR_IMEM and WR_DMEM go to WRITE. RD_DMEM goes to RD_REQ. RUN goes to RUN, or to DONE if the budget is 0.
- **WRITE:**
  - Drives `wen_ext` (WR_IMEM) or `wen_ext_2` (WR_DMEM) high for exactly one cycle, with the latched address and data.
  - Next state is DONE.
- **RD_REQ:** `ren_ext_2`=1 with `addr_ext_2`=latched address. Next state is RD_CAP.
- **RD_CAP:** captures `rdata_ext_2` into `resp_data`. Next state is DONE.
- **RUN:**
  - `enable`=1. A down-counter is loaded with the budget.
  - The counter decrements each RUN cycle. Leave RUN after the cycle where the counter is 1.
  - `enable` is therefore high for exactly N consecutive cycles.
  - `resp_data` is set to N, zero-extended.
- **DONE:** `resp_valid`=1 for one cycle. Next state is IDLE.
- Invariants:
  - All `wen_*` and `ren_*` outputs are 0 whenever `enable`=1.
  - Outside the single active cycle, address and data outputs hold their last values, and their enables are 0.
- `ren_ext` is tied 0. Instruction memory is write-only from this block.
- Commands presented while busy are not accepted. The host holds `cmd_valid` until the handshake completes.

## Timing

- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `enable`=0. All `wen`/`ren` outputs 0. All address, data and `resp_data` registers 0. `resp_valid`=0. `run_cycles`=0.
- Reset mid-operation: outputs take their reset values on that edge, and the command is abandoned with no `resp_valid`. A write already issued to memory is not undone.
- Latency, counted from the accept edge (cycle 0):
  - WR_* and RD_DMEM: `resp_valid` asserts in cycle 3.
  - RUN N≥1: `enable` is high in cycles 1..N, and `resp_valid` asserts in cycle N+1.
  - RUN N=0: `enable` is never asserted, and `resp_valid` asserts in cycle 1 with `resp_data`=0.
- Back-to-back: `cmd_ready` returns in the cycle after `resp_valid`. The minimum command period is therefore 4 cycles for memory commands.
- Budget of all-ones (2^CNT_W−1): handled exactly. The counter does not wrap.
- `cmd_valid` asserted in the same cycle as `rst`: ignored.

## Configuration

- Macro `CPU_RUN_CTRL_CYCLE_COUNT_EN`.
- **Defined:** `run_cycles` increments by 1 every cycle `enable`=1.
  - It wraps modulo 2^CNT_W.
  - It clears only on `rst`, so it accumulates across RUN commands.
- **Undefined:** the `run_cycles` port and its counter are absent, and no other behaviour changes.

## Test plan

- **Reset then idle:** after `rst` is pulsed 2 cycles, expect `cmd_ready`=1, `enable`=0, all `wen`/`ren`=0, `resp_valid`=0.
- **WR_IMEM:** `cmd_addr`=0x8, `cmd_wdata`=0x00500093. Expect `wen_ext`=1 for exactly one cycle with `addr_ext`=0x8 and `wdata_ext`=0x00500093, then `resp_valid` in cycle 3.
- **WR_DMEM then RD_DMEM:** write 0xDEADBEEF_CAFEF00D to 0x40, then read 0x40.
  - Expect `ren_ext_2` for one cycle, then `resp_data`=0xDEADBEEF_CAFEF00D with `resp_valid` in cycle 3.
- **RUN with budget 5:**
  - Expect `enable` high for exactly 5 cycles, no `wen`/`ren` during them, and `resp_data`=5.
  - With the macro defined, `run_cycles` goes 0→5. A second RUN with budget 3 gives `run_cycles`=8.
- **RUN with budget 0:** expect no `enable`, `resp_valid` in cycle 1, `resp_data`=0.
- **Reset during RUN:** budget 100, `rst` asserted in cycle 10. Expect `enable`=0 on the next edge, no `resp_valid`, and `cmd_ready`=1 after reset.
